// File: rtl/baud_gen_frac.sv
// Fractional baud generator: os_tick every act_int + act_frac/2^FRAC_W clocks
// on average, with bit_tick every OSR os_ticks and mid_tick at os_tick OSR/2 of a bit.
// Divisor reloads are double-buffered and take effect on an interval boundary.
module baud_gen_frac #(
  parameter int CLK_FREQ     = 125_000_000,
  parameter int DEFAULT_BAUD = 115200,
  parameter int OSR          = 16,
  parameter int DIV_W        = 16,
  parameter int FRAC_W       = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_phase_sync,
  input  logic              i_div_load,
  input  logic [DIV_W-1:0]  i_div_int,
  input  logic [FRAC_W-1:0] i_div_frac,
  output logic              o_div_pending,
  output logic              o_os_tick,
  output logic              o_bit_tick,
  output logic              o_mid_tick
);

  localparam int OS_W = (OSR > 2) ? $clog2(OSR) : 1;
  localparam longint DEF_FIX = (longint'(CLK_FREQ) << FRAC_W) /
                               (longint'(DEFAULT_BAUD) * longint'(OSR));
  localparam logic [DIV_W-1:0]  DEF_INT  = DIV_W'(DEF_FIX >> FRAC_W);
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(DEF_FIX);
  localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OSR - 1);
  localparam logic [OS_W-1:0]   OS_MID   = OS_W'(OSR / 2 - 1);

  logic [DIV_W-1:0]  r_cnt;
  logic [FRAC_W-1:0] r_acc;
  logic              r_carry;
  logic [OS_W-1:0]   r_os_cnt;
  logic              r_en;
  logic [DIV_W-1:0]  r_act_int, r_sh_int;
  logic [FRAC_W-1:0] r_act_frac, r_sh_frac;
  logic              r_pending;
  logic              r_os_tick, r_bit_tick, r_mid_tick;

  logic [DIV_W:0]    w_len_m1;
  logic              w_term;
  logic [FRAC_W:0]   w_sum;
  logic              w_restart;
  logic              w_idle;
  logic [DIV_W-1:0]  w_ld_int;

  // Interval length is act_int plus the carry earned at the previous boundary;
  // one extra bit so a full-scale divisor with carry still compares correctly.
  assign w_len_m1  = {1'b0, r_act_int} + {{DIV_W{1'b0}}, r_carry} - {{DIV_W{1'b0}}, 1'b1};
  assign w_term    = ({1'b0, r_cnt} == w_len_m1);
  assign w_sum     = {1'b0, r_acc} + {1'b0, r_act_frac};
  // A rising enable behaves exactly like a phase re-sync.
  assign w_restart = i_en & (i_phase_sync | ~r_en);
  assign w_idle    = ~i_en | w_restart;
  // A zero divisor would never terminate; clamp so the fastest rate is one tick per clock.
  assign w_ld_int  = (i_div_int == '0) ? DIV_W'(1) : i_div_int;

  // Interval counter, fractional accumulator and tick generation.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_en       <= 1'b0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_carry    <= 1'b0;
      r_os_cnt   <= '0;
      r_os_tick  <= 1'b0;
      r_bit_tick <= 1'b0;
      r_mid_tick <= 1'b0;
    end else begin
      r_en <= i_en;
      if (w_idle) begin
        r_cnt      <= '0;
        r_acc      <= '0;
        r_carry    <= 1'b0;
        r_os_cnt   <= '0;
        r_os_tick  <= 1'b0;
        r_bit_tick <= 1'b0;
        r_mid_tick <= 1'b0;
      end else if (w_term) begin
        r_cnt            <= '0;
        {r_carry, r_acc} <= w_sum;
        r_os_tick        <= 1'b1;
        r_bit_tick       <= (r_os_cnt == OS_LAST);
        r_mid_tick       <= (r_os_cnt == OS_MID);
        r_os_cnt         <= (r_os_cnt == OS_LAST) ? '0 : r_os_cnt + 1'b1;
      end else begin
        r_cnt      <= r_cnt + 1'b1;
        r_os_tick  <= 1'b0;
        r_bit_tick <= 1'b0;
        r_mid_tick <= 1'b0;
      end
    end
  end

  // Divisor shadow/active pair: loads wait for a boundary unless the generator is idle or restarting.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_act_int  <= DEF_INT;
      r_act_frac <= DEF_FRAC;
      r_sh_int   <= DEF_INT;
      r_sh_frac  <= DEF_FRAC;
      r_pending  <= 1'b0;
    end else if (w_idle) begin
      if (i_div_load) begin
        r_act_int  <= w_ld_int;
        r_act_frac <= i_div_frac;
        r_sh_int   <= w_ld_int;
        r_sh_frac  <= i_div_frac;
      end else if (r_pending) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
      end
      r_pending <= 1'b0;
    end else begin
      // The boundary applies what was already in the shadow; a load in the same
      // cycle lands in the shadow and waits for the following boundary.
      if (w_term && r_pending) begin
        r_act_int  <= r_sh_int;
        r_act_frac <= r_sh_frac;
        r_pending  <= 1'b0;
      end
      if (i_div_load) begin
        r_sh_int  <= w_ld_int;
        r_sh_frac <= i_div_frac;
        r_pending <= 1'b1;
      end
    end
  end

  assign o_div_pending = r_pending;
  assign o_os_tick     = r_os_tick;
  assign o_bit_tick    = r_bit_tick;
  assign o_mid_tick    = r_mid_tick;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: two instances (OSR=16 and OSR=4) share stimulus and
// are tracked every cycle by an event-time reference model.
module tb_baud_gen_frac;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, en = 1'b0, sync = 1'b0, load = 1'b0;
  logic [15:0] dint = '0;
  logic [3:0]  dfrac = '0;
  logic        pend_a, os_a, bit_a, mid_a;
  logic        pend_b, os_b, bit_b, mid_b;

  always #5 clk = ~clk;

  baud_gen_frac dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_phase_sync(sync), .i_div_load(load),
    .i_div_int(dint), .i_div_frac(dfrac), .o_div_pending(pend_a), .o_os_tick(os_a),
    .o_bit_tick(bit_a), .o_mid_tick(mid_a));

  baud_gen_frac #(.OSR(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_phase_sync(sync), .i_div_load(load),
    .i_div_int(dint), .i_div_frac(dfrac), .o_div_pending(pend_b), .o_os_tick(os_b),
    .o_bit_tick(bit_b), .o_mid_tick(mid_b));

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: keeps the absolute cycle of the next os_tick instead of a counter.
  int     m_osr [2] = '{16, 4};
  longint cyc = 0;
  longint m_due [2];
  int     m_act_i [2], m_act_f [2], m_sh_i [2], m_sh_f [2], m_acc [2], m_idx [2];
  bit     m_pend [2], m_os [2], m_bit [2], m_mid [2];
  bit     m_en_prev = 1'b0;

  task automatic model_edge();
    int cl;
    bit restart;
    cl = (dint == 0) ? 1 : int'(dint);
    restart = en && (sync || !m_en_prev);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        longint fix;
        fix = (longint'(125_000_000) * 16) / (longint'(115200) * m_osr[k]);
        m_act_i[k] = int'(fix / 16);
        m_act_f[k] = int'(fix % 16);
        m_pend[k] = 0; m_os[k] = 0; m_bit[k] = 0; m_mid[k] = 0;
      end else if (!en || restart) begin
        m_os[k] = 0; m_bit[k] = 0; m_mid[k] = 0;
        if (load) begin m_act_i[k] = cl; m_act_f[k] = int'(dfrac); end
        else if (m_pend[k]) begin m_act_i[k] = m_sh_i[k]; m_act_f[k] = m_sh_f[k]; end
        m_pend[k] = 0;
        m_acc[k] = 0;
        m_idx[k] = 0;
        m_due[k] = cyc + m_act_i[k];
      end else begin
        if (cyc == m_due[k]) begin
          int s, c;
          m_os[k]  = 1;
          m_bit[k] = (m_idx[k] % m_osr[k]) == m_osr[k] - 1;
          m_mid[k] = (m_idx[k] % m_osr[k]) == m_osr[k] / 2 - 1;
          m_idx[k]++;
          s = m_acc[k] + m_act_f[k];
          c = s / 16;
          m_acc[k] = s % 16;
          if (m_pend[k]) begin m_act_i[k] = m_sh_i[k]; m_act_f[k] = m_sh_f[k]; m_pend[k] = 0; end
          m_due[k] = cyc + m_act_i[k] + c;
        end else begin
          m_os[k] = 0; m_bit[k] = 0; m_mid[k] = 0;
        end
        if (load) begin m_sh_i[k] = cl; m_sh_f[k] = int'(dfrac); m_pend[k] = 1; end
      end
    end
    m_en_prev = rst_n ? en : 1'b0;
    cyc++;
  endtask

  // One clock: advance the model at the edge, compare both instances just after it.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("os_a", os_a, m_os[0]);   chk("bit_a", bit_a, m_bit[0]);
    chk("mid_a", mid_a, m_mid[0]); chk("pend_a", pend_a, m_pend[0]);
    chk("os_b", os_b, m_os[1]);   chk("bit_b", bit_b, m_bit[1]);
    chk("mid_b", mid_b, m_mid[1]); chk("pend_b", pend_b, m_pend[1]);
  endtask

  function automatic logic sig(input int sel, input int kind);
    case ({sel[0], kind[1:0]})
      3'b000:  return os_a;
      3'b001:  return bit_a;
      3'b010:  return mid_a;
      3'b100:  return os_b;
      3'b101:  return bit_b;
      default: return mid_b;
    endcase
  endfunction

  // Steps until the chosen output is high; n = clocks taken.
  task automatic wait_ev(input int sel, input int kind, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      step();
      n++;
      hit = sig(sel, kind);
    end
    if (!hit) begin
      n_chk++;
      n_fail++;
      $display("FAIL wait_timeout: sel %0d kind %0d got no event, expected one within %0d clks", sel, kind, budget);
    end
  endtask

  typedef struct {
    bit rst_n, en, sync, load;
    logic [15:0] di;
    logic [3:0]  df;
    bit os, bt, md, pd;
  } vec_t;

  vec_t tbl [24];

  initial begin
    int n, n68, nbad;
    int exp_sp [5];

    // Reset, idle load of int=0, enable at one tick per clock, then a reload to 3.
    for (int i = 0; i < 24; i++)
      tbl[i] = '{rst_n: 1, en: 1, sync: 0, load: 0, di: 16'd0, df: 4'd0, os: 0, bt: 0, md: 0, pd: 0};
    tbl[0].rst_n = 0; tbl[0].en = 0;
    tbl[1].en = 0;    tbl[1].load = 1;
    for (int i = 3; i <= 20; i++) tbl[i].os = 1;
    tbl[10].md = 1;
    tbl[18].bt = 1;
    tbl[19].load = 1; tbl[19].di = 16'd3; tbl[19].pd = 1;
    tbl[23].os = 1;

    for (int i = 0; i < 24; i++) begin
      rst_n = tbl[i].rst_n; en = tbl[i].en; sync = tbl[i].sync; load = tbl[i].load;
      dint = tbl[i].di; dfrac = tbl[i].df;
      step();
      chk($sformatf("tbl%0d_os", i), os_a, tbl[i].os);
      chk($sformatf("tbl%0d_bit", i), bit_a, tbl[i].bt);
      chk($sformatf("tbl%0d_mid", i), mid_a, tbl[i].md);
      chk($sformatf("tbl%0d_pend", i), pend_a, tbl[i].pd);
    end
    load = 0; dint = '0;

    // Defaults after reset: 67 + 13/16 clocks per os_tick.
    rst_n = 0; step();
    rst_n = 1; en = 1;
    wait_ev(0, 0, 200, n);
    chk("en_rise_first_tick", n, 68);
    n68 = 0; nbad = 0;
    for (int i = 0; i < 32; i++) begin
      wait_ev(0, 0, 200, n);
      if (n == 68) n68++;
      else if (n != 67) nbad++;
    end
    chk("def_spacing_out_of_range", nbad, 0);
    chk("def_68_count_of_32", n68, 26);
    wait_ev(0, 1, 1200, n);
    // 16 consecutive intervals always earn exactly 13 carries.
    wait_ev(0, 1, 1200, n);
    chk("def_bit_period", n, 1085);

    // int=4 frac=8 loaded with a sync: spacing 4,4,5,4,5; OSR=4 marks 2nd and 4th ticks.
    load = 1; dint = 16'd4; dfrac = 4'd8; sync = 1; step();
    load = 0; sync = 0;
    exp_sp = '{4, 4, 5, 4, 5};
    for (int i = 0; i < 5; i++) begin
      wait_ev(1, 0, 50, n);
      chk($sformatf("frac_spacing%0d", i), n, exp_sp[i]);
      chk($sformatf("frac_mid%0d", i), mid_b, (i == 1));
      chk($sformatf("frac_bit%0d", i), bit_b, (i == 3));
    end

    // Mid-interval reload: old interval finishes, boundary carry still uses old frac.
    sync = 1; step(); sync = 0;
    wait_ev(0, 0, 50, n);
    chk("reload_sync_first", n, 4);
    step();
    load = 1; dint = 16'd10; dfrac = 4'd0; step(); load = 0;
    chk("reload_pending_set", pend_a, 1);
    step();
    chk("reload_pending_hold", pend_a, 1);
    step();
    chk("reload_old_spacing_tick", os_a, 1);
    chk("reload_pending_clear", pend_a, 0);
    wait_ev(0, 0, 50, n);
    chk("reload_first_new", n, 11);
    wait_ev(0, 0, 50, n);
    chk("reload_steady", n, 10);

    // Sync mid-bit with int=6 frac=0: ticks drop, next tick 6 later, bit after 16 ticks.
    load = 1; dint = 16'd6; dfrac = 4'd0; step(); load = 0;
    for (int i = 0; i < 3; i++) wait_ev(0, 0, 50, n);
    step(); step();
    sync = 1; step(); sync = 0;
    chk("sync_os_low", os_a, 0);
    wait_ev(0, 0, 50, n);
    chk("sync_next_tick", n, 6);
    wait_ev(0, 1, 200, n);
    chk("sync_bit_after", n, 90);

    // Reset during an interval with a pending load: default rate returns.
    step();
    load = 1; dint = 16'd20; step(); load = 0;
    chk("rst_pending_before", pend_a, 1);
    rst_n = 0; step();
    chk("rst_pend", pend_a, 0);
    chk("rst_os", os_a, 0);
    rst_n = 1;
    wait_ev(0, 0, 200, n);
    chk("rst_first_tick", n, 68);
    wait_ev(0, 0, 200, n);
    chk("rst_second_tick", n, 67);

    // Random traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      en    = ($urandom_range(0, 59) != 0);
      sync  = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 24) == 0);
      dint  = 16'($urandom_range(0, 12));
      dfrac = 4'($urandom_range(0, 15));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1);
  end

endmodule
